parity_pipelined_adder: RTL
===========================

Name: parity_pipelined_adder

Overview:
- Parametrised successor to the single-register adder/memory pair.
- Computes a registered (WORD_WIDTH+1)-bit sum {cout,sum} of in_a + in_b + cin.
- Carries the sum through LAYERS pipeline registers, each protected by one even-parity bit, and checks parity at every stage.
- Has a built-in single-bit fault-injection port, so soft-error benchmarks can flip any stored bit and observe detection.

Parameters:
- WORD_WIDTH, 4, operand and sum width in bits (>=1).
- LAYERS, 3, number of pipeline stages; this equals the latency (>=1).
- CNT_WIDTH, 8, width of the saturating error counter.
- STG_W, $clog2(LAYERS) (min 1), width of the stage-index fields.
- BIT_W, $clog2(WORD_WIDTH+2), width of the bit-index field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operands valid this cycle.
- cin  in  1  carry in.
- in_a  in  WORD_WIDTH  operand A.
- in_b  in  WORD_WIDTH  operand B.
- sum  out  WORD_WIDTH  result from the last stage.
- cout  out  1  carry from the last stage.
- out_valid  out  1  valid bit of the last stage.
- out_err  out  1  parity mismatch on the last stage; combinational; qualified by out_valid.
- err_flag  out  1  sticky error flag; registered.
- err_stage  out  STG_W  lowest stage index of the first recorded error.
- err_count  out  CNT_WIDTH  saturating count of corrupted words delivered.
- err_clr  in  1  clears err_flag and err_stage.
- inj_en  in  1  fault-injection strobe.
- inj_stage  in  STG_W  target stage.
- inj_bit  in  BIT_W  target bit: 0..WORD_WIDTH-1 = sum bits, WORD_WIDTH = carry, WORD_WIDTH+1 = parity bit.

Behaviour:
- Stage k (k = 0..LAYERS-1) holds data_k[WORD_WIDTH:0], par_k and vld_k.
- Reset (rst_n=0 at a clk edge):
  - all data_k, par_k and vld_k = 0;
  - err_flag = 0, err_stage = 0, err_count = 0.
  - Reset overrides injection and err_clr. Words in flight are discarded.
  - Outputs after reset: sum = 0, cout = 0, out_valid = 0, out_err = 0.
- Free-running pipeline with no stall; every stage updates every cycle.
  - Stage 0 loads data_0 = in_a + in_b + cin, computed at WORD_WIDTH+1 bits with no overflow loss.
  - Stage 0 loads par_0 = ^(that value) and vld_0 = in_valid.
  - Stage k>0 loads data_k, par_k and vld_k from stage k-1 unchanged. Parity is forwarded, never regenerated, so a corruption stays detectable downstream.
  - Data/parity registers load even when the source is invalid; vld tracks validity.
- Latency: operands sampled at edge n appear on sum/cout/out_valid after edge n+LAYERS-1, i.e. LAYERS edges counting the capture edge.
- Injection:
  - At an edge with inj_en=1, the selected stage stores its normal next value with one bit inverted.
  - inj_bit = WORD_WIDTH+1 inverts par_k instead of a data bit.
  - inj_stage >= LAYERS or inj_bit > WORD_WIDTH+1: no effect.
  - Injection applies regardless of vld.
- Mismatch: mis_k = vld_k & (^data_k != par_k).
  - out_err = mis_{LAYERS-1} (combinational).
  - A double flip in the same word is undetected (parity limit); this is accepted.
- err_flag/err_stage:
  - At an edge where any mis_k=1 and err_flag=0: err_flag <= 1 and err_stage <= lowest k with mis_k.
  - While err_flag=1, err_stage holds.
  - err_clr=1 with no mismatch that cycle: err_flag <= 0, err_stage <= 0.
  - err_clr=1 in the same cycle as a mismatch: the new error wins (flag set, stage recaptured).
- err_count:
  - +1 at each edge where out_valid & out_err; saturates at 2^CNT_WIDTH-1.
  - Cleared only by reset, not by err_clr.

Test Plan (WORD_WIDTH=4, LAYERS=3):
1. Reset, then in_valid=1, in_a=4'hF, in_b=4'h1, cin=1 for one cycle -> after 3 edges: out_valid=1, {cout,sum}=5'h11, out_err=0, err_flag=0.
2. Back-to-back stream (3+4+0 = 7, 9+9+1 = 19, 15+15+0 = 30) -> outputs 5'h07, 5'h13, 5'h1E on consecutive cycles, with out_valid high for exactly 3 cycles.
3. Operands 2+3+0, with inj_en=1, inj_stage=1, inj_bit=0 on the edge the word enters stage 1 -> mismatch detected at stage 1:
   - next cycle err_flag=1, err_stage=1;
   - on delivery sum=4'h4, out_err=1, err_count=1.
4. inj_bit=5 (parity bit) on stage 2 of a valid word -> data delivered intact, out_err=1, err_stage=2. Injection into a stage with vld=0 -> no flag.
5. err_clr pulsed alone -> err_flag=0, err_stage=0, err_count unchanged. err_clr in the same cycle as a new stage-0 mismatch -> err_flag=1, err_stage=0.
6. rst_n=0 mid-stream with inj_en=1 and 3 words in flight -> next cycle all outputs and counters are 0 and no stale word emerges. CNT_WIDTH=2 with 5 corrupted words -> err_count saturates at 3.

Source files
------------

// File: rtl/parity_pipelined_adder.sv
// rtl/parity_pipelined_adder.sv - adder feeding a parity-protected pipeline with fault injection
// Stage 0 captures {cout,sum}; later stages shift it unchanged and every stage is parity-checked.
module parity_pipelined_adder #(
    parameter int WORD_WIDTH = 4,
    parameter int LAYERS     = 3,
    parameter int CNT_WIDTH  = 8,
    parameter int STG_W      = (LAYERS > 1) ? $clog2(LAYERS) : 1,
    parameter int BIT_W      = $clog2(WORD_WIDTH + 2)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  cin,
    input  logic [WORD_WIDTH-1:0] in_a,
    input  logic [WORD_WIDTH-1:0] in_b,
    output logic [WORD_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  out_valid,
    output logic                  out_err,
    output logic                  err_flag,
    output logic [STG_W-1:0]      err_stage,
    output logic [CNT_WIDTH-1:0]  err_count,
    input  logic                  err_clr,
    input  logic                  inj_en,
    input  logic [STG_W-1:0]      inj_stage,
    input  logic [BIT_W-1:0]      inj_bit
);

    localparam int DW = WORD_WIDTH + 1;

    logic [LAYERS-1:0][DW-1:0] data_q, data_n;
    logic [LAYERS-1:0]         par_q, par_n;
    logic [LAYERS-1:0]         vld_q, vld_n;
    logic [LAYERS-1:0]         mis;
    logic [DW-1:0]             add_res;
    logic [DW-1:0]             flip_mask;
    logic                      flip_par;
    logic                      any_mis;
    logic [STG_W-1:0]          first_stg;

    assign add_res = {1'b0, in_a} + {1'b0, in_b} + {{WORD_WIDTH{1'b0}}, cin};

    // Out-of-range bit indices shift the single 1 off the top, leaving an empty mask.
    assign flip_mask = DW'(1) << inj_bit;
    assign flip_par  = (inj_bit == BIT_W'(WORD_WIDTH + 1));

    always_comb begin
        data_n = '0;
        par_n  = '0;
        vld_n  = '0;
        for (int k = 0; k < LAYERS; k++) begin
            if (k == 0) begin
                data_n[k] = add_res;
                par_n[k]  = ^add_res;
                vld_n[k]  = in_valid;
            end else begin
                data_n[k] = data_q[k-1];
                par_n[k]  = par_q[k-1];
                vld_n[k]  = vld_q[k-1];
            end
            if (inj_en && (32'(inj_stage) == k)) begin
                data_n[k] = data_n[k] ^ flip_mask;
                par_n[k]  = par_n[k] ^ flip_par;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
            par_q  <= '0;
            vld_q  <= '0;
        end else begin
            data_q <= data_n;
            par_q  <= par_n;
            vld_q  <= vld_n;
        end
    end

    always_comb begin
        mis       = '0;
        first_stg = '0;
        for (int k = 0; k < LAYERS; k++) begin
            mis[k] = vld_q[k] & ((^data_q[k]) != par_q[k]);
        end
        for (int k = LAYERS - 1; k >= 0; k--) begin
            if (mis[k]) begin
                first_stg = STG_W'(k);
            end
        end
    end

    assign any_mis = |mis;

    assign sum       = data_q[LAYERS-1][WORD_WIDTH-1:0];
    assign cout      = data_q[LAYERS-1][WORD_WIDTH];
    assign out_valid = vld_q[LAYERS-1];
    assign out_err   = mis[LAYERS-1];

    // A clear coinciding with a fresh mismatch re-arms the flag with the new stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_flag  <= 1'b0;
            err_stage <= '0;
        end else if (any_mis && (!err_flag || err_clr)) begin
            err_flag  <= 1'b1;
            err_stage <= first_stg;
        end else if (err_clr) begin
            err_flag  <= 1'b0;
            err_stage <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (out_valid && out_err && (err_count != {CNT_WIDTH{1'b1}})) begin
            err_count <= err_count + CNT_WIDTH'(1);
        end
    end

endmodule
